// File: rtl/stream_xform_fifo.sv
// stream_xform_fifo
// Valid/ready stream stage that transforms each accepted word according to a
// per-word mode, then buffers the result in a small FIFO so that consumer
// stalls never drop or corrupt data. The transform is applied on the way in,
// so a mode change only affects words accepted after the change.
module stream_xform_fifo #(
    parameter int          DATA_W = 8,
    parameter int          DEPTH  = 4,
    parameter int unsigned ROT    = 1,
    parameter int unsigned KEY    = 'hA5
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [1:0]                 mode_i,
    input  logic                       flush_i,
    input  logic [DATA_W-1:0]          in_data_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic [DATA_W-1:0]          out_data_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic [15:0]                drop_cnt_o
);

    localparam int          PTR_W    = $clog2(DEPTH);
    localparam int          LVL_W    = $clog2(DEPTH+1);
    localparam int unsigned ROT_AMT  = ROT % DATA_W;
    localparam int unsigned SWAP_AMT = DATA_W / 2;
    localparam logic [DATA_W-1:0] KEY_V     = DATA_W'(KEY);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [15:0]       DROP_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_ROTX = 2'd1,
        MODE_INV  = 2'd2,
        MODE_SWAP = 2'd3
    } mode_e;

    // Left rotate: the upper half of the doubled word shifted left is the rotation.
    function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] d,
                                                input int unsigned amt);
        logic [2*DATA_W-1:0] dd;
        dd = {d, d} << amt;
        return dd[2*DATA_W-1:DATA_W];
    endfunction

    // Storage and state
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q,  level_d;
    logic [15:0]       drop_q,   drop_d;

    logic [DATA_W-1:0] xform_data;
    logic              push;
    logic              pop;
    logic              drop_inc;

    // Transform of the incoming word, selected by the mode sampled with it.
    // Swapping halves is a rotate by DATA_W/2, which also covers odd widths.
    always_comb begin
        xform_data = in_data_i;
        unique case (mode_e'(mode_i))
            MODE_PASS: xform_data = in_data_i;
            MODE_ROTX: xform_data = rotl(in_data_i, ROT_AMT) ^ KEY_V;
            MODE_INV:  xform_data = ~in_data_i;
            MODE_SWAP: xform_data = rotl(in_data_i, SWAP_AMT);
            default:   xform_data = in_data_i;
        endcase
    end

    // Handshake decode. in_ready depends only on registered level, never on
    // out_ready, so a full FIFO does not accept a word even if it pops that cycle.
    always_comb begin
        in_ready_o  = rst_n_i && !flush_i && (level_q < LVL_FULL);
        out_valid_o = rst_n_i && (level_q != '0);
        out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
        level_o     = level_q;
        drop_cnt_o  = drop_q;
        push        = in_valid_i && in_ready_o;
        pop         = out_valid_o && out_ready_i && !flush_i;
        drop_inc    = in_valid_i && !in_ready_o;
    end

    // Next-state for pointers, occupancy and the saturating drop counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        drop_d   = drop_q;

        if (drop_inc && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + 16'd1;
        end

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Control state register; reset discards contents by clearing occupancy.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
        end
    end

    // Data storage: written only on an accepted push, contents need no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= xform_data;
        end
    end

endmodule

// File: tb/tb_stream_xform_fifo.sv
// Bench for stream_xform_fifo: directed steps plus randomized traffic, all
// outputs compared every cycle against a queue-based reference model.
module tb_stream_xform_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic          flush;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    level;
    logic [15:0]   drop_cnt;

    always #5 clk = ~clk;

    stream_xform_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .ROT(1), .KEY('hA5)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .mode_i      (mode),
        .flush_i     (flush),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .level_o     (level),
        .drop_cnt_o  (drop_cnt)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  q [$];
    int unsigned drop_m      = 0;
    logic        chk_en      = 1'b0;
    logic        stall_prev  = 1'b0;
    logic [7:0]  data_prev   = 8'h00;

    // Reference transform computed with plain integer arithmetic.
    function automatic logic [7:0] model_xf(input logic [1:0] m, input logic [7:0] d);
        int v;
        v = int'(d);
        case (m)
            2'd0:    return d;
            2'd1:    return 8'(((v * 2) + (v / 128)) % 256) ^ 8'hA5;
            2'd2:    return 8'(255 - v);
            default: return 8'(((v % 16) * 16) + (v / 16));
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare at negedge, advance the model at posedge, return #1 later.
    task automatic cycle();
        logic       exp_ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        @(negedge clk);
        exp_ready = rst_n && !flush && (q.size() < DEPTH);
        exp_valid = (q.size() != 0);
        exp_data  = exp_valid ? q[0] : 8'h00;
        if (chk_en) begin
            if (!rst_n) begin
                chk("rst_in_ready", 32'(in_ready), 32'(1'b0));
                chk("rst_out_data", 32'(out_data), 32'(8'h00));
            end else begin
                chk("level",     32'(level),     32'(q.size()));
                chk("out_valid", 32'(out_valid), 32'(exp_valid));
                chk("out_data",  32'(out_data),  32'(exp_data));
                chk("in_ready",  32'(in_ready),  32'(exp_ready));
                chk("drop_cnt",  32'(drop_cnt),  32'(drop_m));
                if (stall_prev) chk("stable", 32'(out_data), 32'(data_prev));
            end
        end
        stall_prev = rst_n && !flush && exp_valid && !out_ready;
        data_prev  = exp_data;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            drop_m = 0;
        end else begin
            if (in_valid && !exp_ready && drop_m != 32'hFFFF) drop_m++;
            if (flush) begin
                q.delete();
            end else begin
                if (exp_valid && out_ready) begin
                    $display("pop  %02h lvl=%0d", q[0], q.size() - 1);
                    void'(q.pop_front());
                end
                if (in_valid && exp_ready) begin
                    q.push_back(model_xf(mode, in_data));
                    $display("push %02h m%0d -> %02h lvl=%0d", in_data, mode,
                             model_xf(mode, in_data), q.size());
                end
            end
        end
        #1;
    endtask

    logic [7:0]  exp2 [4];
    int          pushed;
    int          base;

    initial begin
        rst_n = 1'b0; mode = 2'd0; flush = 1'b0; in_data = 8'h00;
        in_valid = 1'b0; out_ready = 1'b0;
        exp2[0] = 8'hA6; exp2[1] = 8'hF0; exp2[2] = 8'hA5; exp2[3] = 8'h00;

        // Reset
        cycle(); cycle();
        chk_en = 1'b1;
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("reset_drop", 32'(drop_cnt), 32'd0);

        // 1: single ROTX word
        mode = 2'd1; in_data = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("t1_data", 32'(out_data), 32'(8'hDD));
        chk("t1_level1", 32'(level), 32'd1);
        cycle();
        chk("t1_level0", 32'(level), 32'd0);

        // 2: fill with mixed modes, then drain in order
        out_ready = 1'b0; in_valid = 1'b1;
        mode = 2'd1; in_data = 8'h81; cycle();
        mode = 2'd2; in_data = 8'h0F; cycle();
        mode = 2'd3; in_data = 8'h5A; cycle();
        mode = 2'd0; in_data = 8'h00; cycle();
        in_valid = 1'b0;
        chk("t2_level", 32'(level), 32'd4);
        chk("t2_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain", 32'(out_data), 32'(exp2[i]));
            cycle();
        end

        // 3: overflow attempts while full, then concurrent push/pop
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mode = 2'($urandom); in_data = 8'($urandom); cycle();
        end
        base = int'(drop_m);
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom); cycle();
        end
        chk("t3_drop", 32'(drop_cnt), 32'(base + 3));
        chk("t3_level_full", 32'(level), 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mode = 2'($urandom); in_data = 8'($urandom); cycle();
        end
        chk("t3_level_steady", 32'(level), 32'd3);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // 4: random traffic with random back-pressure
        pushed = 0;
        for (int c = 0; c < 3000 && pushed < 200; c++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            mode      = 2'($urandom);
            in_data   = 8'($urandom);
            if (in_valid && q.size() < DEPTH) pushed++;
            cycle();
        end
        chk("t4_pushed", 32'(pushed), 32'd200);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) cycle();
        cycle();
        chk("t4_empty", 32'(out_valid), 32'd0);

        // 5: flush at level 3 with a word offered
        out_ready = 1'b0; in_valid = 1'b1; mode = 2'd0;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom); cycle();
        end
        chk("t5_level3", 32'(level), 32'd3);
        base = int'(drop_m);
        flush = 1'b1; in_data = 8'h99;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_level0", 32'(level), 32'd0);
        chk("t5_valid0", 32'(out_valid), 32'd0);
        chk("t5_drop", 32'(drop_cnt), 32'(base + 1));
        in_valid = 1'b1; in_data = 8'h11;
        cycle();
        in_valid = 1'b0;
        chk("t5_alone_lvl", 32'(level), 32'd1);
        chk("t5_alone_data", 32'(out_data), 32'(8'h11));
        out_ready = 1'b1;
        cycle();
        chk("t5_after_pop", 32'(level), 32'd0);

        // 6: pointer wrap at low occupancy, then reset mid-stream
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mode = 2'($urandom); in_data = 8'($urandom); cycle();
        end
        out_ready = 1'b0;
        in_data = 8'h42; cycle();
        in_data = 8'h43; cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1; in_valid = 1'b0;
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_drop", 32'(drop_cnt), 32'd0);
        in_valid = 1'b1; mode = 2'd0; in_data = 8'h77;
        cycle();
        in_valid = 1'b0;
        chk("t6_first_out", 32'(out_data), 32'(8'h77));
        out_ready = 1'b1;
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
